// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the instruction path.
// Holds the loader state encoding, the default stream byte width, the
// length-byte convention and the 8-bit instruction field layout.
package loader_pkg;

  // Default stream / instruction byte width (one ins_code per byte).
  localparam int LOADER_DATA_W = 8;

  // A length byte of zero describes a full 2^ADDR_W-byte program rather
  // than an empty one.
  localparam bit LEN_ZERO_IS_FULL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_e;

  // Instruction byte layout shared with the control decoder:
  // [7:6] opcode, [5:3] first register field, [2:0] second register field.
  typedef struct packed {
    logic [1:0] opcode;
    logic [2:0] field_a;
    logic [2:0] field_b;
  } ins_code_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: byte-stream writer for the instruction memory.
// Accepts a frame of [length][N instruction bytes][XOR checksum] over a
// valid/ready channel, writes the instruction bytes to addresses 0..N-1 and
// releases the processor (cpu_run) only after the checksum verifies.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     request a new load (honoured in IDLE, DONE, ERR)
//   abort     return to IDLE on the next edge, from any state
//   in_valid  in_data holds a stream byte
//   in_data   stream byte
//   in_ready  loader accepts a byte this cycle
//   im_we     instruction memory write strobe
//   im_addr   instruction memory write address
//   im_wdata  instruction memory write data
//   cpu_run   high only in DONE; gates processor reset
//   done      load finished with a good checksum (sticky)
//   error     checksum mismatch (sticky)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, stream closed
// LEN   | waiting for the length byte
// DATA  | writing instruction bytes, accumulating the XOR checksum
// CSUM  | waiting for the checksum byte
// DONE  | verified load, processor released
// ERR   | checksum mismatch, processor held in reset
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  loader_state_e     state, state_d;
  logic [ADDR_W-1:0] count, count_d;
  logic [ADDR_W-1:0] len, len_d;
  logic [DATA_W-1:0] csum, csum_d;
  logic              accept;
  logic              in_ready_d;
  logic              im_we_d;
  logic [ADDR_W-1:0] im_addr_d;
  logic [DATA_W-1:0] im_wdata_d;
  logic              cpu_run_d;
  logic              done_d;
  logic              error_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      len      <= '0;
      csum     <= '0;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      len      <= len_d;
      csum     <= csum_d;
      in_ready <= in_ready_d;
      im_we    <= im_we_d;
      im_addr  <= im_addr_d;
      im_wdata <= im_wdata_d;
      cpu_run  <= cpu_run_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

  always_comb begin
    state_d    = state;
    count_d    = count;
    len_d      = len;
    csum_d     = csum;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr;
    im_wdata_d = im_wdata;
    // in_ready is registered and is high exactly in LEN/DATA/CSUM, so it
    // doubles as the "this state listens to the stream" qualifier.
    accept     = in_valid & in_ready;

    case (state)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          len_d   = ADDR_W'(in_data);
          count_d = '0;
          csum_d  = '0;
          if (!LEN_ZERO_IS_FULL && (in_data == '0)) state_d = CSUM;
          else                                      state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          im_we_d    = 1'b1;
          im_addr_d  = count;
          im_wdata_d = in_data;
          csum_d     = csum ^ in_data;
          // count wraps to 0 on the last byte of a full-size program.
          count_d    = count + ADDR_ONE;
          if (count == (len - ADDR_ONE)) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == csum) state_d = DONE;
          else                 state_d = ERR;
        end
      end
      DONE, ERR: begin
        if (start) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase

    // abort beats start and byte acceptance, and kills the write that the
    // accepted byte would otherwise have produced next cycle.
    if (abort) begin
      state_d = IDLE;
      im_we_d = 1'b0;
    end

    in_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    done_d     = (state_d == DONE);
    cpu_run_d  = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       im_we;
  logic [7:0] im_addr;
  logic [7:0] im_wdata;
  logic       cpu_run;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] frame_q[$];
  int         gap_q[$];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_run  (cpu_run),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: records every strobe seen mid-cycle.
  always @(negedge clk) begin
    if (reset && im_we) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // Called at posedge+1; leaves the bench at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    bit ok;
    bit taken;
    taken = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !taken; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) taken = 1'b1;
    end
    in_valid = 1'b0;
    if (!taken) check_eq("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Reference: a frame describes N writes of its payload at 0..N-1 and
  // succeeds iff the XOR of the payload equals the trailing byte.
  task automatic run_load(input string name, input bit b2b);
    int n;
    logic [7:0] x;
    n = (frame_q[0] == 8'h00) ? 256 : int'(frame_q[0]);
    x = 8'h00;
    for (int i = 1; i <= n; i++) x ^= frame_q[i];
    clear_writes();
    pulse_start();
    for (int i = 0; i < frame_q.size(); i++) drive_byte(frame_q[i], gap_q[i]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq({name, " nwr"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check_eq({name, " wr"}, {wr_addr_q[i], wr_data_q[i]}, {i[7:0], frame_q[i+1]});
      if (b2b && i > 0) check_eq({name, " b2b"}, wr_cyc_q[i] - wr_cyc_q[i-1], 1);
    end
    check_eq({name, " done"},     done,     (x == frame_q[n+1]));
    check_eq({name, " cpu_run"},  cpu_run,  (x == frame_q[n+1]));
    check_eq({name, " error"},    error,    (x != frame_q[n+1]));
    check_eq({name, " in_ready"}, in_ready, 1'b0);
    #1;
  endtask

  task automatic set_basic(input logic [7:0] cs);
    frame_q = '{8'h03, 8'h41, 8'h8A, 8'h05, cs};
    gap_q   = '{0, 0, 0, 0, 0};
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {in_ready, im_we, im_addr, im_wdata, cpu_run, done, error}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_eq("idle in_ready", in_ready, 1'b0);

    // Basic load
    set_basic(8'hCE);
    run_load("basic", 1'b1);

    // start in DONE: flags drop, LEN entered
    pulse_start();
    @(negedge clk);
    check_eq("restart done",     done,     1'b0);
    check_eq("restart cpu_run",  cpu_run,  1'b0);
    check_eq("restart in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    pulse_abort();
    check_eq("abort_len in_ready", in_ready, 1'b0);

    // Bad checksum
    set_basic(8'h00);
    run_load("badcs", 1'b1);

    // Stall between 0x8A and 0x05
    set_basic(8'hCE);
    gap_q[3] = 2;
    run_load("stall", 1'b0);
    if (wr_cyc_q.size() == 3) begin
      check_eq("stall spacing01", wr_cyc_q[1] - wr_cyc_q[0], 1);
      check_eq("stall spacing12", wr_cyc_q[2] - wr_cyc_q[1], 3);
    end else begin
      check_eq("stall nwr", wr_cyc_q.size(), 3);
    end

    // Full 256-byte program
    frame_q.delete(); gap_q.delete();
    frame_q.push_back(8'h00); gap_q.push_back(0);
    for (int i = 0; i < 256; i++) begin
      frame_q.push_back(i[7:0]); gap_q.push_back(0);
    end
    frame_q.push_back(8'h00); gap_q.push_back(0);
    run_load("full", 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("full no_extra_wr", wr_addr_q.size(), 256);
    #1;

    // Reset mid-load after the second data byte
    @(posedge clk); #1;
    clear_writes();
    pulse_start();
    drive_byte(8'h03, 0);
    drive_byte(8'h41, 0);
    drive_byte(8'h8A, 0);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midreset outputs");
    @(posedge clk); #1;
    check_all_zero("midreset held");
    reset = 1'b1;
    @(posedge clk); #1;
    set_basic(8'hCE);
    run_load("after_reset", 1'b1);

    // Abort in DATA with a byte being accepted the same cycle
    @(posedge clk); #1;
    clear_writes();
    pulse_start();
    drive_byte(8'h03, 0);
    drive_byte(8'h41, 0);
    in_valid = 1'b1; in_data = 8'h8A; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("abort in_ready", in_ready, 1'b0);
    check_eq("abort im_we",    im_we,    1'b0);
    check_eq("abort done",     done,     1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("abort nwr", wr_addr_q.size(), 1);
    #1;

    // Randomized frames against the reference
    for (int r = 0; r < 25; r++) begin
      int n;
      logic [7:0] x;
      logic [7:0] b;
      frame_q.delete(); gap_q.delete();
      n = $urandom_range(1, 24);
      frame_q.push_back(n[7:0]); gap_q.push_back($urandom_range(0, 2));
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        x ^= b;
        frame_q.push_back(b); gap_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      if ($urandom_range(0, 1) == 1) frame_q.push_back(x);
      else                           frame_q.push_back(8'($urandom));
      gap_q.push_back($urandom_range(0, 1));
      run_load("rand", 1'b0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader; the writer side of the instruction memory that ins_fetch reads.
- Accepts a framed program over a valid/ready byte channel: length byte, N instruction bytes, then an XOR checksum byte.
- Writes the N instruction bytes into instruction memory at addresses 0..N-1.
- Releases the processor via cpu_run only after a verified load; the top level drives processor reset as (reset & cpu_run).

Parameters:
- ADDR_W, 8, instruction memory address width; maximum program is 2^ADDR_W bytes.
- DATA_W, 8, instruction and stream byte width; matches the 8-bit ins_code format.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- abort, input, 1, return to IDLE from any state on the next edge.
- in_valid, input, 1, in_data holds a valid stream byte.
- in_data, input, DATA_W, stream byte.
- in_ready, output, 1, loader can accept a byte this cycle.
- im_we, output, 1, instruction memory write strobe, one cycle per byte.
- im_addr, output, ADDR_W, write address.
- im_wdata, output, DATA_W, write data.
- cpu_run, output, 1, high only in DONE; gates processor reset.
- done, output, 1, load completed with a good checksum.
- error, output, 1, checksum mismatch.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready, im_we, im_addr, im_wdata, cpu_run, done and error are all 0.
  - Internal count, len and csum are 0.
- All outputs are registered.
- A byte is consumed only on a cycle where in_valid and in_ready are both 1.
- in_valid while in_ready=0 is ignored; the byte is not consumed.
- IDLE: in_ready=0. start=1 moves to LEN; in_ready=1 from the next cycle.
- LEN:
  - The accepted byte is the program length; 0 encodes 2^ADDR_W.
  - Clears count and csum, then moves to DATA.
- DATA, for each accepted byte:
  - One cycle later: im_we=1, im_addr=count, im_wdata=byte.
  - csum becomes csum ^ byte; count increments.
  - When the accepted byte is the last (count == len-1, modulo 2^ADDR_W), move to CSUM.
  - in_ready stays 1, so one byte per cycle is sustained; gaps in in_valid stall with no write and count held.
  - im_we is 0 on cycles with no accepted byte.
- CSUM:
  - Accepted byte equal to csum: go to DONE, with done=1 and cpu_run=1 on the next cycle.
  - Mismatch: go to ERR, with error=1 and cpu_run=0.
  - Memory writes already issued are not rolled back.
- DONE / ERR:
  - in_ready=0; done, error and cpu_run are sticky.
  - start=1 clears done, error and cpu_run on the next edge and enters LEN.
- start asserted in LEN, DATA or CSUM is ignored.
- abort=1 in any state:
  - Next state IDLE; in_ready, done, error and cpu_run go to 0.
  - A write strobe already scheduled for the next cycle is suppressed.
  - abort has priority over start and over byte acceptance in the same cycle.
- Address wrap: with len=0, addresses run 0..2^ADDR_W-1. count wraps to 0 exactly as the transition to CSUM occurs; there is no write past the top address.
- reset mid-load: immediate return to IDLE with all outputs 0. Partial memory contents are undefined for the processor, which is held in reset because cpu_run=0.
- Checksum arithmetic: DATA_W-bit XOR over the instruction bytes only; the length byte is excluded.

Decomposition:
- Shared package (loader_pkg) holds:
  - The state enum: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - A DATA_W default of 8.
  - The LEN_ZERO_IS_FULL convention constant.
  - The opcode field positions [7:6], [5:3], [2:0], shared with control.
- Single module; no sub-module warranted. Counter, checksum and FSM all fit in one file.

Test Plan:
- Basic load: start, then 0x03, 0x41, 0x8A, 0x05, 0xCE back-to-back.
  - Required: writes (0,0x41), (1,0x8A), (2,0x05) on consecutive cycles.
  - Required: done=1 and cpu_run=1; error=0.
- Bad checksum: same stream but final byte 0x00.
  - Required: three writes occur, then error=1, cpu_run=0, done=0, in_ready=0.
- Stall: same stream as the basic load with in_valid low for 2 cycles between 0x8A and 0x05.
  - Required: no im_we during the gap; im_addr=2 for the 0x05 write; done=1.
- Full program: length 0x00, then 256 bytes of value i, then checksum 0x00.
  - Required: 256 writes to addresses 0..255 with no write after 255.
  - Required: done=1 (XOR of 0..255 is 0x00).
- Reset mid-load: reset low after the second data byte of the basic load.
  - Required: all outputs 0 asynchronously.
  - Required: after reset release, start plus a full basic stream ends with done=1.
- Abort and restart:
  - abort in DATA: IDLE, in_ready=0, the pending write is suppressed.
  - start in DONE: done and cpu_run drop next cycle, LEN entered, in_ready=1.
